// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//   Packet-based round-robin arbiter sharing the write port of one
//   asynchronous FIFO among NUM_REQ requesters. Runs entirely in the FIFO
//   write clock domain. A grant lasts from the first beat of a packet to the
//   beat carrying req_last, or is force-released after MAX_BURST beats.
//
// Ports
//   wclk, wrst_n   write-domain clock, async active-low reset
//   req_valid      per-requester beat valid
//   req_data       packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-requester final-beat flag
//   req_ready      per-requester ready; beat accepted when valid & ready
//   fifo_full      FIFO full flag (write domain)
//   fifo_w_en      FIFO write enable
//   fifo_wdata     FIFO write data (granted requester's slice)
//   grant_id       current / most recent granted requester
//   busy           high while a grant is active
//   burst_trunc    one-cycle pulse after a grant is cut at MAX_BURST beats
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  localparam int GW        = $clog2(NUM_REQ),
  localparam int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          burst_trunc
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] beat_cnt;
  logic          next_found;
  logic [GW-1:0] next_id;

  // Round-robin search: scan from the requester after the last winner,
  // wrapping around, and take the first one with a valid beat pending.
  always_comb begin
    next_found = 1'b0;
    next_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!next_found && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        next_found = 1'b1;
        next_id    = GW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  // Only the granted requester ever sees ready, and only while the FIFO
  // has room; everyone else keeps holding their beat.
  always_comb begin
    req_ready = '0;
    if (state == GRANT && !fifo_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Write enable is combinational so a beat moves in the same cycle that
  // valid and ready meet. The data mux follows grant_id at all times.
  assign fifo_w_en  = (state == GRANT) && req_valid[grant_id] && !fifo_full;
  assign fifo_wdata = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state == GRANT);

  // Grant FSM. IDLE arbitrates for one cycle, GRANT streams beats until
  // req_last or the burst limit. A transfer that is both last and at the
  // limit counts as a normal end, so req_last is tested first.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      beat_cnt    <= '0;
      burst_trunc <= 1'b0;
    end else begin
      burst_trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (next_found) begin
            grant_id <= next_id;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (fifo_w_en) begin
            if (req_last[grant_id]) begin
              state      <= IDLE;
              last_grant <= grant_id;
              beat_cnt   <= '0;
            end else if (beat_cnt == CW'(MAX_BURST - 1)) begin
              state       <= IDLE;
              last_grant  <= grant_id;
              beat_cnt    <= '0;
              burst_trunc <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter with NUM_REQ=4, DATA_WIDTH=8,
//   MAX_BURST=16. Inputs change 1ns after the rising edge; outputs are
//   compared 1ns later, well clear of either clock edge.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_wdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic        burst_trunc;

  int vectors;
  int miscompares;
  int wr_count;
  int full_write_violations;
  int wr_base;
  logic [31:0] d;

  fifo_write_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .MAX_BURST(16)
  ) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en),
    .fifo_wdata(fifo_wdata),
    .grant_id(grant_id),
    .busy(busy),
    .burst_trunc(burst_trunc)
  );

  // Free-running write clock, 10ns period
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // Count FIFO writes and catch any write issued while the FIFO is full
  always @(negedge wclk) begin
    if (fifo_w_en) wr_count++;
    if (fifo_w_en && fifo_full) full_write_violations++;
  end

  task automatic stepCycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] dat, input logic f);
    req_valid = v;
    req_last  = l;
    req_data  = dat;
    fifo_full = f;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_wen"}, 32'(fifo_w_en), 32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic checkBeat(input string tag, input logic [1:0] g, input logic [7:0] dat);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_gid"}, 32'(grant_id), 32'(g));
    checkOutput({tag, "_wen"}, 32'(fifo_w_en), 32'd1);
    checkOutput({tag, "_wdata"}, 32'(fifo_wdata), 32'(dat));
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << g));
  endtask

  // Directed sequence: each step sets inputs for the coming edge, then
  // compares against hand-derived values.
  initial begin
    vectors = 0;
    miscompares = 0;
    wr_count = 0;
    full_write_violations = 0;
    wrst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

    // Reset state
    stepCycle();
    stepCycle();
    checkIdle("reset");
    checkOutput("reset_gid", 32'(grant_id), 32'd0);
    checkOutput("reset_trunc", 32'(burst_trunc), 32'd0);
    wrst_n = 1'b1;
    stepCycle();

    // Test 1: single 3-beat packet from requester 0
    wr_base = wr_count;
    applyStimulus(4'b0001, 4'b0000, 32'h0000_00A1, 1'b0);
    checkIdle("t1_arb");
    stepCycle();
    checkBeat("t1_b0", 2'd0, 8'hA1);
    stepCycle();
    applyStimulus(4'b0001, 4'b0000, 32'h0000_00A2, 1'b0);
    checkBeat("t1_b1", 2'd0, 8'hA2);
    stepCycle();
    applyStimulus(4'b0001, 4'b0001, 32'h0000_00A3, 1'b0);
    checkBeat("t1_b2", 2'd0, 8'hA3);
    stepCycle();
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkIdle("t1_end");
    checkOutput("t1_gid_hold", 32'(grant_id), 32'd0);
    checkOutput("t1_writes", 32'(wr_count - wr_base), 32'd3);

    // Test 2: all requesters valid with 1-beat packets; last winner was 0
    applyStimulus(4'b1111, 4'b1111, 32'h1312_1110, 1'b0);
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      checkBeat("t2_grant", 2'((1 + k) % 4), 8'(8'h10 + (1 + k) % 4));
      stepCycle();
      checkIdle("t2_gap");
    end
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

    // Test 3: requester 2 sends 20 beats, requester 0 waits with one beat
    d = 32'h0020_0055;
    applyStimulus(4'b0101, 4'b0001, d, 1'b0);
    stepCycle();
    for (int b = 0; b < 16; b++) begin
      d[23:16] = 8'(8'h20 + b);
      applyStimulus(4'b0101, 4'b0001, d, 1'b0);
      checkBeat("t3_burst", 2'd2, d[23:16]);
      checkOutput("t3_no_trunc", 32'(burst_trunc), 32'd0);
      stepCycle();
    end
    d[23:16] = 8'h30;
    applyStimulus(4'b0101, 4'b0001, d, 1'b0);
    checkIdle("t3_cut");
    checkOutput("t3_trunc", 32'(burst_trunc), 32'd1);
    checkOutput("t3_cut_gid", 32'(grant_id), 32'd2);
    stepCycle();
    checkBeat("t3_other", 2'd0, 8'h55);
    checkOutput("t3_trunc_once", 32'(burst_trunc), 32'd0);
    stepCycle();
    applyStimulus(4'b0100, 4'b0000, d, 1'b0);
    checkIdle("t3_gap");
    stepCycle();
    for (int b = 0; b < 4; b++) begin
      d[23:16] = 8'(8'h30 + b);
      applyStimulus(4'b0100, (b == 3) ? 4'b0100 : 4'b0000, d, 1'b0);
      checkBeat("t3_resume", 2'd2, d[23:16]);
      stepCycle();
    end
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkIdle("t3_end");
    checkOutput("t3_end_trunc", 32'(burst_trunc), 32'd0);

    // Test 4: FIFO full for 5 cycles mid-packet from requester 3
    wr_base = wr_count;
    applyStimulus(4'b1000, 4'b0000, 32'h4100_0000, 1'b0);
    stepCycle();
    checkBeat("t4_b0", 2'd3, 8'h41);
    stepCycle();
    applyStimulus(4'b1000, 4'b0000, 32'h4200_0000, 1'b1);
    for (int s = 0; s < 5; s++) begin
      checkOutput("t4_stall_wen", 32'(fifo_w_en), 32'd0);
      checkOutput("t4_stall_ready", 32'(req_ready), 32'd0);
      checkOutput("t4_stall_busy", 32'(busy), 32'd1);
      if (s < 4) stepCycle();
    end
    stepCycle();
    applyStimulus(4'b1000, 4'b0000, 32'h4200_0000, 1'b0);
    checkBeat("t4_b1", 2'd3, 8'h42);
    stepCycle();
    applyStimulus(4'b1000, 4'b0000, 32'h4300_0000, 1'b0);
    checkBeat("t4_b2", 2'd3, 8'h43);
    stepCycle();
    applyStimulus(4'b1000, 4'b1000, 32'h4400_0000, 1'b0);
    checkBeat("t4_b3", 2'd3, 8'h44);
    stepCycle();
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkIdle("t4_end");
    checkOutput("t4_writes", 32'(wr_count - wr_base), 32'd4);

    // Test 5: requester 0 drops valid for 3 cycles while 1 waits
    wr_base = wr_count;
    applyStimulus(4'b0011, 4'b0010, 32'h0000_7761, 1'b0);
    stepCycle();
    checkBeat("t5_b0", 2'd0, 8'h61);
    stepCycle();
    applyStimulus(4'b0010, 4'b0010, 32'h0000_7761, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput("t5_gap_wen", 32'(fifo_w_en), 32'd0);
      checkOutput("t5_gap_ready", 32'(req_ready), 32'b0001);
      checkOutput("t5_gap_gid", 32'(grant_id), 32'd0);
      checkOutput("t5_gap_busy", 32'(busy), 32'd1);
      stepCycle();
    end
    applyStimulus(4'b0011, 4'b0010, 32'h0000_7762, 1'b0);
    checkBeat("t5_b1", 2'd0, 8'h62);
    stepCycle();
    applyStimulus(4'b0011, 4'b0011, 32'h0000_7763, 1'b0);
    checkBeat("t5_b2", 2'd0, 8'h63);
    stepCycle();
    checkIdle("t5_gap");
    stepCycle();
    checkBeat("t5_next", 2'd1, 8'h77);
    stepCycle();
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkIdle("t5_end");
    checkOutput("t5_writes", 32'(wr_count - wr_base), 32'd4);

    // Test 6: reset on beat 2 of requester 2's packet
    applyStimulus(4'b0101, 4'b0000, 32'h0091_0081, 1'b0);
    stepCycle();
    checkBeat("t6_b0", 2'd2, 8'h91);
    stepCycle();
    applyStimulus(4'b0101, 4'b0000, 32'h0092_0081, 1'b0);
    checkBeat("t6_b1", 2'd2, 8'h92);
    wrst_n = 1'b0;
    #1;
    checkIdle("t6_rst");
    checkOutput("t6_rst_gid", 32'(grant_id), 32'd0);
    checkOutput("t6_rst_trunc", 32'(burst_trunc), 32'd0);
    stepCycle();
    stepCycle();
    wrst_n = 1'b1;
    #1;
    checkIdle("t6_rel");
    stepCycle();
    checkBeat("t6_first", 2'd0, 8'h81);
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    stepCycle();

    checkOutput("no_write_while_full", 32'(full_write_violations), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
